param_addr_gen: RTL
===================

PARAM_ADDR_GEN -- requirements
Module: param_addr_gen

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width.
REQ-002 SHALL have parameter LEN_W, default 20, transfer-length and counter width.
REQ-003 SHALL have parameter DIM_W, default 12, width of window, image and stride fields.
REQ-004 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-006 SHALL have ports start in 1 (launch) and abort in 1 (terminate run).
REQ-007 SHALL have port mode  in  2  00 SEQ, 01 WIN2D, 10 CIRC, 11 reserved (treated as SEQ).
REQ-008 SHALL have ports base_addr in ADDR_W and length in LEN_W (number of addresses to emit).
REQ-009 SHALL have ports win_w, win_h, img_w, stride, each in DIM_W, for WIN2D.
REQ-010 SHALL have ports buf_len in LEN_W and start_off in LEN_W, for CIRC.
REQ-011 SHALL have ports addr out ADDR_W, addr_valid out 1, addr_ready in 1, addr_last out 1.
REQ-012 SHALL have ports busy out 1, done out 1 (one-cycle pulse), stall_cnt out LEN_W.

Function
REQ-013 SHALL implement states IDLE, RUN, DONE; DONE lasts exactly one cycle, then IDLE.
REQ-014 SHALL, on start in IDLE, latch all config inputs; config changes during RUN have no effect.
REQ-015 SHALL enter RUN the cycle after start when length>0, with first addr=base_addr (CIRC: base_addr+start_off) and addr_valid=1.
REQ-016 SHALL, when length==0, go IDLE->DONE->IDLE, emitting no addresses.
REQ-017 SHALL advance only on handshake (addr_valid && addr_ready); addr/addr_last stay stable while addr_valid && !addr_ready.
REQ-018 SHALL sustain one address per cycle when addr_ready is held high.
REQ-019 SHALL assert addr_last with the length-th address; its handshake moves RUN->DONE and drops addr_valid.
REQ-020 SHALL ignore start while not in IDLE; busy = (state != IDLE).
REQ-021 SHALL on abort in RUN go to DONE next cycle, addr_valid low; a handshake in the same cycle completes, then aborts.
REQ-022 SEQ: address i = base_addr + i.
REQ-023 WIN2D: addr = base_addr + (orow+kr)*img_w + ocol + kc; kc inner loop 0..win_w-1, then kr 0..win_h-1.
REQ-024 WIN2D: after full window, ocol += stride if ocol+stride+win_w <= img_w, else ocol=0 and orow += stride; windows never straddle row end.
REQ-025 WIN2D: SHALL use an incrementally updated row-base register; no runtime multiplier on the address path.
REQ-026 CIRC: offset starts at start_off mod buf_len, increments, wraps to 0 at buf_len; addr = base_addr + offset; buf_len==0 treated as 1.
REQ-027 SHALL compute all addresses modulo 2^ADDR_W (natural wrap, no saturation).

Reset
REQ-028 SHALL, on rst, force state=IDLE asynchronously; addr=0, addr_valid=0, addr_last=0, busy=0, done=0, stall_cnt=0.
REQ-029 SHALL, on rst mid-RUN, drop addr_valid immediately and not emit done.

Configuration
REQ-030 SHALL, with PARAM_AGU_STALL_CNT_EN defined, count cycles with addr_valid && !addr_ready, cleared on start, saturating at all-ones.
REQ-031 SHALL, without PARAM_AGU_STALL_CNT_EN, tie stall_cnt to 0 and omit the counter logic.

Verification
REQ-032 SEQ, base=0x100, length=4, ready=1 -> 0x100,0x101,0x102,0x103 on consecutive cycles, last on 0x103, done next cycle.
REQ-033 WIN2D, base=0, img_w=5, win 3x3, stride=2, length=18 -> 0,1,2,5,6,7,10,11,12, then 2,3,4,7,8,9,12,13,14.
REQ-034 CIRC, base=0x40, buf_len=4, start_off=2, length=6 -> 0x42,0x43,0x40,0x41,0x42,0x43.
REQ-035 SEQ, length=3, ready low for cycles 2-4 -> addr 0x1 held stable, stall_cnt=3 (macro on) or 0 (off).
REQ-036 abort on 2nd handshake cycle of length=8 -> exactly 2 addresses accepted, done pulse, then IDLE.
REQ-037 rst asserted mid-RUN, then start with length=0 -> outputs zero immediately on rst; afterwards done pulses with no addr_valid.

Source files
------------

// File: rtl/param_addr_gen.sv
// Parameterised address generator: emits a stream of addresses over a
// valid/ready handshake in one of three patterns (sequential, 2-D sliding
// window, circular buffer).
// Optional feature macro: PARAM_AGU_STALL_CNT_EN enables the back-pressure
// stall counter on stall_cnt; when undefined, stall_cnt is tied to zero.
module param_addr_gen #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LEN_W  = 20,
  parameter int unsigned DIM_W  = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  length,
  input  logic [DIM_W-1:0]  win_w,
  input  logic [DIM_W-1:0]  win_h,
  input  logic [DIM_W-1:0]  img_w,
  input  logic [DIM_W-1:0]  stride,
  input  logic [LEN_W-1:0]  buf_len,
  input  logic [LEN_W-1:0]  start_off,
  output logic [ADDR_W-1:0] addr,
  output logic              addr_valid,
  input  logic              addr_ready,
  output logic              addr_last,
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  typedef enum logic [1:0] {M_SEQ, M_WIN, M_CIRC} amode_t;

  localparam logic [DIM_W:0] D_ONE = (DIM_W+1)'(1);
  localparam logic [LEN_W:0] L_ONE = (LEN_W+1)'(1);

  state_t              state_q;
  amode_t              mode_q;
  logic [ADDR_W-1:0]   base_q;
  logic [DIM_W-1:0]    win_w_q;
  logic [DIM_W-1:0]    win_h_q;
  logic [DIM_W-1:0]    img_w_q;
  logic [DIM_W-1:0]    stride_q;
  logic [LEN_W-1:0]    blen_q;
  logic [ADDR_W-1:0]   stride_row_q;

  logic [LEN_W-1:0]    rem_q;
  logic [DIM_W-1:0]    kc_q;
  logic [DIM_W-1:0]    kr_q;
  logic [DIM_W-1:0]    ocol_q;
  logic [ADDR_W-1:0]   row_q;
  logic [ADDR_W-1:0]   wrow_q;
  logic [LEN_W-1:0]    off_q;

  logic [2*DIM_W-1:0]  prod;
  logic [LEN_W-1:0]    blen_in;
  logic [LEN_W-1:0]    off_start;

  logic [DIM_W-1:0]    kc_n;
  logic [DIM_W-1:0]    kr_n;
  logic [DIM_W-1:0]    ocol_n;
  logic [ADDR_W-1:0]   row_n;
  logic [ADDR_W-1:0]   wrow_n;
  logic [LEN_W-1:0]    off_n;
  logic [ADDR_W-1:0]   addr_n;
  logic [DIM_W:0]      kc_inc;
  logic [DIM_W:0]      kr_inc;
  logic [DIM_W+1:0]    fit_sum;
  logic [LEN_W:0]      off_inc;

  logic                hs;

  function automatic amode_t decode_mode(input logic [1:0] m);
    case (m)
      2'b01:   return M_WIN;
      2'b10:   return M_CIRC;
      default: return M_SEQ;
    endcase
  endfunction

  assign busy = (state_q != S_IDLE);
  assign hs   = addr_valid && addr_ready;

  // Launch-time constants: row stride product and circular start offset are
  // evaluated once when the run is latched, never per address.
  always_comb begin
    prod      = {{DIM_W{1'b0}}, stride} * {{DIM_W{1'b0}}, img_w};
    blen_in   = (buf_len == '0) ? LEN_W'(1) : buf_len;
    off_start = start_off % blen_in;
  end

  // Next address and pattern counters, applied only on a handshake.
  // The window walk keeps row_q (current kernel row) and wrow_q (window top
  // row) as running pointers so every step is an add, not a multiply.
  always_comb begin
    kc_n    = kc_q;
    kr_n    = kr_q;
    ocol_n  = ocol_q;
    row_n   = row_q;
    wrow_n  = wrow_q;
    off_n   = off_q;
    addr_n  = addr + ADDR_W'(1);
    kc_inc  = {1'b0, kc_q} + D_ONE;
    kr_inc  = {1'b0, kr_q} + D_ONE;
    fit_sum = {2'b00, ocol_q} + {2'b00, stride_q} + {2'b00, win_w_q};
    off_inc = {1'b0, off_q} + L_ONE;
    case (mode_q)
      M_WIN: begin
        if (kc_inc >= {1'b0, win_w_q}) begin
          kc_n = '0;
          if (kr_inc >= {1'b0, win_h_q}) begin
            kr_n = '0;
            if (fit_sum <= {2'b00, img_w_q}) begin
              ocol_n = ocol_q + stride_q;
              row_n  = wrow_q;
              addr_n = wrow_q + ADDR_W'(ocol_n);
            end else begin
              ocol_n = '0;
              wrow_n = wrow_q + stride_row_q;
              row_n  = wrow_n;
              addr_n = wrow_n;
            end
          end else begin
            kr_n   = kr_inc[DIM_W-1:0];
            row_n  = row_q + ADDR_W'(img_w_q);
            addr_n = row_n + ADDR_W'(ocol_q);
          end
        end else begin
          kc_n = kc_inc[DIM_W-1:0];
        end
      end
      M_CIRC: begin
        if (off_inc >= {1'b0, blen_q}) begin
          off_n  = '0;
          addr_n = base_q;
        end else begin
          off_n  = off_inc[LEN_W-1:0];
        end
      end
      default: ;
    endcase
  end

  // Control FSM with registered handshake outputs and run state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      mode_q       <= M_SEQ;
      base_q       <= '0;
      win_w_q      <= '0;
      win_h_q      <= '0;
      img_w_q      <= '0;
      stride_q     <= '0;
      blen_q       <= '0;
      stride_row_q <= '0;
      rem_q        <= '0;
      kc_q         <= '0;
      kr_q         <= '0;
      ocol_q       <= '0;
      row_q        <= '0;
      wrow_q       <= '0;
      off_q        <= '0;
      addr         <= '0;
      addr_valid   <= 1'b0;
      addr_last    <= 1'b0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            mode_q       <= decode_mode(mode);
            base_q       <= base_addr;
            win_w_q      <= win_w;
            win_h_q      <= win_h;
            img_w_q      <= img_w;
            stride_q     <= stride;
            blen_q       <= blen_in;
            stride_row_q <= ADDR_W'(prod);
            rem_q        <= length;
            kc_q         <= '0;
            kr_q         <= '0;
            ocol_q       <= '0;
            row_q        <= base_addr;
            wrow_q       <= base_addr;
            off_q        <= off_start;
            if (length == '0) begin
              state_q <= S_DONE;
              done    <= 1'b1;
            end else begin
              state_q    <= S_RUN;
              addr_valid <= 1'b1;
              addr_last  <= (length == LEN_W'(1));
              addr       <= (decode_mode(mode) == M_CIRC)
                            ? base_addr + ADDR_W'(off_start) : base_addr;
            end
          end
        end
        S_RUN: begin
          if ((hs && addr_last) || abort) begin
            state_q    <= S_DONE;
            addr_valid <= 1'b0;
            addr_last  <= 1'b0;
            done       <= 1'b1;
          end else if (hs) begin
            rem_q     <= rem_q - LEN_W'(1);
            addr_last <= (rem_q == LEN_W'(2));
            addr      <= addr_n;
            kc_q      <= kc_n;
            kr_q      <= kr_n;
            ocol_q    <= ocol_n;
            row_q     <= row_n;
            wrow_q    <= wrow_n;
            off_q     <= off_n;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

`ifdef PARAM_AGU_STALL_CNT_EN
  logic [LEN_W-1:0] stall_q;

  // Saturating count of cycles an offered address waits for the consumer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else if (state_q == S_IDLE && start) begin
      stall_q <= '0;
    end else if (addr_valid && !addr_ready && stall_q != '1) begin
      stall_q <= stall_q + LEN_W'(1);
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule
